// File: rtl/pong_game_ctrl.sv
// Pong game-level sequencer: new-game / play / new-ball / game-over phases,
// remaining-ball count, two-digit BCD score and the frame-tick pause timer.
module pong_game_ctrl #(
    parameter int BALLS      = 3,
    parameter int WAIT_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [1:0] ball,
    output logic       new_game,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_NEWGAME = 2'd0,
        S_PLAY    = 2'd1,
        S_NEWBALL = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    localparam logic [1:0] BALLS_L = 2'(BALLS);
    localparam logic [6:0] WAIT_L  = 7'(WAIT_TICKS);

    state_t     state_q, state_d;
    logic [6:0] timer_q, timer_d;
    logic [1:0] ball_q, ball_d;
    logic [3:0] dig0_q, dig0_d;
    logic [3:0] dig1_q, dig1_d;
    logic       hit_prev_q, hit_prev_d;

    logic tick, hit_pulse, pressed, timer_up, timer_load;

    assign tick      = (pix_y == 10'd481) && (pix_x == 10'd0);
    assign hit_pulse = hit & ~hit_prev_q;
    assign pressed   = (btn != 2'b00);
    assign timer_up  = (timer_q == 7'd0);

    // Two-digit BCD increment, wrapping 99 -> 00.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] units);
        logic [3:0] t, u;
        t = tens;
        u = units;
        if (u == 4'd9) begin
            u = 4'd0;
            t = (t == 4'd9) ? 4'd0 : t + 4'd1;
        end else begin
            u = u + 4'd1;
        end
        return {t, u};
    endfunction

    always_comb begin
        state_d    = state_q;
        ball_d     = ball_q;
        dig0_d     = dig0_q;
        dig1_d     = dig1_q;
        timer_load = 1'b0;
        hit_prev_d = hit;

        case (state_q)
            S_NEWGAME: begin
                if (pressed) begin
                    ball_d  = BALLS_L - 2'd1;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (hit_pulse) begin
                    {dig1_d, dig0_d} = bcd_inc(dig1_q, dig0_q);
                end
                // A hit and a miss on the same cycle both take effect.
                if (miss) begin
                    timer_load = 1'b1;
                    if (ball_q == 2'd0) begin
                        state_d = S_OVER;
                    end else begin
                        ball_d  = ball_q - 2'd1;
                        state_d = S_NEWBALL;
                    end
                end
            end
            S_NEWBALL: begin
                if (timer_up && pressed) begin
                    state_d = S_PLAY;
                end
            end
            S_OVER: begin
                if (timer_up) begin
                    dig0_d  = 4'd0;
                    dig1_d  = 4'd0;
                    ball_d  = BALLS_L;
                    state_d = S_NEWGAME;
                end
            end
            default: state_d = S_NEWGAME;
        endcase

        if (timer_load) begin
            timer_d = WAIT_L;
        end else if (tick && !timer_up) begin
            timer_d = timer_q - 7'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_NEWGAME;
            timer_q    <= 7'd0;
            ball_q     <= BALLS_L;
            dig0_q     <= 4'd0;
            dig1_q     <= 4'd0;
            hit_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ball_q     <= ball_d;
            dig0_q     <= dig0_d;
            dig1_q     <= dig1_d;
            hit_prev_q <= hit_prev_d;
        end
    end

    assign gra_still = (state_q != S_PLAY);
    assign new_game  = (state_q == S_NEWGAME);
    assign game_over = (state_q == S_OVER);
    assign dig0      = dig0_q;
    assign dig1      = dig1_q;
    assign ball      = ball_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn = 2'b00;
    logic [9:0] pix_x = 10'd1;
    logic [9:0] pix_y = 10'd0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       gra_still, new_game, game_over;
    logic [3:0] dig0, dig1;
    logic [1:0] ball;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       gs, ng, go;
        logic [3:0] d1, d0;
        logic [1:0] b;
        bit         chk_t;
        logic [6:0] t;
    } exp_t;

    exp_t exp_q[$];

    pong_game_ctrl #(.BALLS(3), .WAIT_TICKS(120)) dut (
        .clk(clk), .reset(reset), .btn(btn), .pix_x(pix_x), .pix_y(pix_y),
        .hit(hit), .miss(miss), .gra_still(gra_still), .dig0(dig0), .dig1(dig1),
        .ball(ball), .new_game(new_game), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string n, input logic gs, input logic ng, input logic go,
                             input logic [3:0] d1, input logic [3:0] d0, input logic [1:0] b,
                             input bit ct = 1'b0, input logic [6:0] t = 7'd0);
        exp_t e;
        e.name = n; e.gs = gs; e.ng = ng; e.go = go;
        e.d1 = d1; e.d0 = d0; e.b = b; e.chk_t = ct; e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic hit_pulse();
        hit = 1'b1; step();
        hit = 1'b0; step();
    endtask

    task automatic tick_frame();
        pix_x = 10'd0; pix_y = 10'd481; step();
        pix_x = 10'd1; pix_y = 10'd0;   step();
        step();
    endtask

    // Monitor: outputs are stable half a cycle after the edge.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                bad = (gra_still !== e.gs) || (new_game !== e.ng) || (game_over !== e.go) ||
                      (dig1 !== e.d1) || (dig0 !== e.d0) || (ball !== e.b) ||
                      (e.chk_t && (dut.timer_q !== e.t));
                if (bad) begin
                    errors++;
                    $display("FAIL %s: got gs=%0b ng=%0b go=%0b score=%0d%0d ball=%0d timer=%0d; expected gs=%0b ng=%0b go=%0b score=%0d%0d ball=%0d timer=%0d",
                             e.name, gra_still, new_game, game_over, dig1, dig0, ball, dut.timer_q,
                             e.gs, e.ng, e.go, e.d1, e.d0, e.b, e.t);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(); step();
        checks++;
        if (new_game !== 1'b1) begin
            errors++;
            $display("FAIL reset_direct: got new_game=%0b, expected 1", new_game);
        end
        expect_st("reset", 1, 1, 0, 0, 0, 3, 1'b1, 7'd0);
        reset = 1'b0;
        step();
        expect_st("idle_newgame", 1, 1, 0, 0, 0, 3);

        // Start a game with a one-cycle press
        btn = 2'b01; step(); btn = 2'b00;
        checks++;
        if ((gra_still !== 1'b0) || (ball !== 2'd2)) begin
            errors++;
            $display("FAIL start_direct: got gs=%0b ball=%0d, expected gs=0 ball=2", gra_still, ball);
        end
        expect_st("start_play", 0, 0, 0, 0, 0, 2);

        // Held hit counts once, re-arms after a low cycle
        hit = 1'b1; step();
        checks++;
        if (dig0 !== 4'd1) begin
            errors++;
            $display("FAIL hit_direct: got dig0=%0d, expected 1", dig0);
        end
        expect_st("hit_first", 0, 0, 0, 0, 1, 2);
        repeat (499) step();
        expect_st("hit_held", 0, 0, 0, 0, 1, 2);
        hit = 1'b0; step();
        hit = 1'b1; step();
        expect_st("hit_rearm", 0, 0, 0, 0, 2, 2);
        hit = 1'b0; step();

        // BCD carry and wrap
        repeat (7) hit_pulse();
        expect_st("score_09", 0, 0, 0, 0, 9, 2);
        hit_pulse();
        expect_st("score_10", 0, 0, 0, 1, 0, 2);
        repeat (89) hit_pulse();
        expect_st("score_99", 0, 0, 0, 9, 9, 2);
        hit_pulse();
        checks++;
        if ((dig1 !== 4'd0) || (dig0 !== 4'd0)) begin
            errors++;
            $display("FAIL wrap_direct: got score=%0d%0d, expected 00", dig1, dig0);
        end
        expect_st("score_wrap", 0, 0, 0, 0, 0, 2);

        // Miss with balls left -> NEWBALL, pause then resume with held button
        miss = 1'b1; step(); miss = 1'b0;
        expect_st("miss_newball", 1, 0, 0, 0, 0, 1, 1'b1, 7'd120);
        btn = 2'b10;
        hit_pulse();
        expect_st("hit_ignored", 1, 0, 0, 0, 0, 1);
        repeat (119) tick_frame();
        expect_st("pause_119", 1, 0, 0, 0, 0, 1, 1'b1, 7'd1);
        pix_x = 10'd0; pix_y = 10'd481; step();
        pix_x = 10'd1; pix_y = 10'd0;
        expect_st("tick_120", 1, 0, 0, 0, 0, 1, 1'b1, 7'd0);
        step();
        expect_st("resume_play", 0, 0, 0, 0, 0, 1);
        btn = 2'b00;

        // Reset mid-pause discards the timer
        miss = 1'b1; step(); miss = 1'b0;
        expect_st("miss_last_ball", 1, 0, 0, 0, 0, 0);
        repeat (63) tick_frame();
        expect_st("timer_57", 1, 0, 0, 0, 0, 0, 1'b1, 7'd57);
        step();
        reset = 1'b1;
        #1;
        expect_st("async_reset", 1, 1, 0, 0, 0, 3, 1'b1, 7'd0);
        step(); step();
        reset = 1'b0;
        step();

        // Full game: three misses to OVER, then back to NEWGAME
        btn = 2'b01; step(); btn = 2'b00;
        expect_st("game2_start", 0, 0, 0, 0, 0, 2);
        hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
        expect_st("hit_and_miss", 1, 0, 0, 0, 1, 1);
        btn = 2'b11;
        repeat (120) tick_frame();
        expect_st("game2_resume1", 0, 0, 0, 0, 1, 1);
        miss = 1'b1; step(); miss = 1'b0;
        expect_st("game2_miss2", 1, 0, 0, 0, 1, 0);
        repeat (120) tick_frame();
        expect_st("game2_resume2", 0, 0, 0, 0, 1, 0);
        btn = 2'b00;
        miss = 1'b1; step(); miss = 1'b0;
        expect_st("game_over", 1, 0, 1, 0, 1, 0);
        repeat (119) tick_frame();
        expect_st("over_119", 1, 0, 1, 0, 1, 0);
        pix_x = 10'd0; pix_y = 10'd481; step();
        pix_x = 10'd1; pix_y = 10'd0;
        expect_st("over_tick_120", 1, 0, 1, 0, 1, 0);
        step();
        expect_st("back_newgame", 1, 1, 0, 0, 0, 3);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-level controller for the Pong display path. It sits downstream of the graphics stage: it consumes that stage's `hit`/`miss` flags and the pixel scan position, and feeds `gra_still` back into it. It sequences new-game, play, new-ball and game-over phases, counts remaining balls, keeps a two-digit BCD score, and times the pauses between phases. All outputs are Moore outputs decoded from registers, for the text/score overlay and the graphics stage.

## Interface
- `BALLS`, 3: balls per game (1..3).
- `WAIT_TICKS`, 120: pause length in frame ticks (2 s at 60 Hz); 1..127.
- `clk`  in  1  system clock (pixel-rate domain shared with sync and graphics).
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `btn`  in  2  debounced button levels; "pressed" means `btn != 2'b00`.
- `pix_x`  in  10  current scan column.
- `pix_y`  in  10  current scan row.
- `hit`  in  1  level flag from graphics: ball overlaps paddle (held many cycles).
- `miss`  in  1  level flag from graphics: ball past right border (held until `gra_still`).
- `gra_still`  out  1  freeze and re-centre ball/paddle; high in every state except PLAY.
- `dig0`  out  4  score units digit, BCD.
- `dig1`  out  4  score tens digit, BCD.
- `ball`  out  2  balls remaining after the one in play.
- `new_game`  out  1  high in NEWGAME (rule/title overlay select).
- `game_over`  out  1  high in OVER.

## Operation
- Frame tick: `tick = (pix_y == 481) && (pix_x == 0)`, one cycle per frame, combinational.
- Hit edge: register `hit_d` (reset 0) samples `hit` every cycle; `hit_pulse = hit & ~hit_d`.
- Timer: 7-bit down counter. Loaded with `WAIT_TICKS` on the cycle a transition into NEWBALL or OVER is taken. Otherwise, if nonzero, it decrements on `tick` and holds when zero. `timer_up = (timer == 0)`.
- States:
  - NEWGAME: score held at 00; `ball = BALLS`. If pressed, `ball <= BALLS-1` and go to PLAY.
  - PLAY: `hit_pulse` increments the score. If `miss`: when `ball == 0`, load timer and go to OVER; else `ball <= ball-1`, load timer and go to NEWBALL.
  - NEWBALL: when `timer_up && pressed`, go to PLAY.
  - OVER: when `timer_up`, clear score to 00, set `ball <= BALLS`, and go to NEWGAME.
- Score: BCD increment. `dig0 == 9` gives `dig0 = 0` and a `dig1` increment; `99 + 1 = 00` (wrap, no saturation). Only `hit_pulse` in PLAY increments the score.
- Simultaneous `hit_pulse` and `miss` in PLAY: both take effect; the score increments and the miss transition is taken.
- `hit`/`miss` outside PLAY are ignored; `hit_d` still tracks `hit`.
- Buttons are level-sensitive. A button held through NEWBALL starts play as soon as the timer expires.

## Timing
- Reset values: state NEWGAME, `gra_still = 1`, `new_game = 1`, `game_over = 0`, `dig0 = dig1 = 0`, `ball = BALLS`, `timer = 0`, `hit_d = 0`.
- Reset asserted in any state returns all registers to their reset values immediately; a mid-pause timer is discarded.
- All state, counter and score updates are registered. An input event at edge N is visible on the outputs after edge N+1.
- `miss` sampled at edge N: `gra_still = 1` from N+1. The graphics stage re-centres on the same cycle, so `miss` drops by N+2.
- Pause: NEWBALL/OVER last exactly `WAIT_TICKS` frame ticks after entry, plus up to one frame of phase.
- First hit cycle increments the score once; a `hit` held for any number of cycles gives exactly one increment. It re-arms only after `hit` has been low for at least one cycle.
- `ball` never underflows; `ball == 0` plus `miss` always goes to OVER.

## Test plan
- Reset, then `btn = 01` for 1 cycle: at the next edge PLAY, `gra_still = 0`, `ball = 2`, score 00.
- In PLAY, hold `hit` high for 500 cycles, low, then high again: score 01, then 02.
- Preload the score to 09 and pulse `hit`: `dig1 = 1`, `dig0 = 0`. Preload 99 and pulse `hit`: 00.
- In PLAY with `ball = 2`, assert `miss`: NEWBALL, `ball = 1`, `gra_still = 1`. Hold `btn = 10`: PLAY is re-entered on the cycle after the 120th tick.
- Play 3 misses from a new game: OVER after the third, `game_over = 1`. After 120 ticks: NEWGAME, score 00, `ball = 3`.
- Assert `reset` mid-NEWBALL with the timer at 57: all outputs return to their reset values within the reset assertion, and the timer reads 0.
